// File: rtl/wb_mux_tmo_pkg.sv
// ----------------------------------------------------------------------------
// wb_mux_tmo_pkg
// Shared types and constants for the wb_mux_tmo Wishbone interconnect and its
// address decoder.
//   state_e       : per-cycle interconnect state (IDLE/ACTIVE/DERR/TERR)
//   CTI_*         : Wishbone B4 cycle type identifier encodings
//   IDX_W         : width of a slave index (supports up to 16 slaves)
//   cti_is_burst  : true when the cycle type says another beat follows
// ----------------------------------------------------------------------------
package wb_mux_tmo_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DERR   = 2'd2,
      TERR   = 2'd3
   } state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam int IDX_W = 4;

   // A terminated beat keeps the slave selected only for constant or
   // incrementing bursts; classic, end-of-burst and reserved codes release it.
   function automatic logic cti_is_burst(input logic [2:0] cti);
      return (cti == CTI_CONST) || (cti == CTI_INCR);
   endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// ----------------------------------------------------------------------------
// wb_addr_decode
// Combinational priority address match against a table of base/mask pairs.
// Slave i matches when (adr & MASK_i) == (ADDR_i & MASK_i); on overlap the
// lowest index wins.
//   adr_i : address to decode
//   hit_o : some slave matched
//   idx_o : index of the winning slave (0 when no hit)
// ----------------------------------------------------------------------------
module wb_addr_decode
   import wb_mux_tmo_pkg::*;
#(
   parameter int                       NUM_SLAVES = 8,
   parameter int                       AW         = 32,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '1
)(
   input  logic [AW-1:0]    adr_i,
   output logic             hit_o,
   output logic [IDX_W-1:0] idx_o
);

   // Priority match: scanning from the highest index down lets a lower
   // matching index overwrite a higher one, so the lowest index wins.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((adr_i & MATCH_MASK[i*AW +: AW]) ==
             (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(i);
         end else begin
            hit_o = hit_o;
            idx_o = idx_o;
         end
      end
   end

endmodule

// File: rtl/wb_mux_tmo.sv
// ----------------------------------------------------------------------------
// wb_mux_tmo
// Single-master, N-slave Wishbone B4 classic/burst interconnect with a
// registered address decode, bus error on unmapped addresses, a watchdog that
// terminates hung slave cycles, and a captured fault address.
//   wb_clk_i, wb_rst_n_i        : clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o           : master side (adr/dat/sel/we/cyc/stb/cti/bte
//                                 in; dat/ack/err/rty out)
//   wbs_*_o / wbs_*_i           : slave side, flattened per slave; adr/dat/
//                                 sel/we/cti/bte broadcast, cyc/stb one-hot
//   fault_o                     : one-cycle pulse on decode miss or timeout
//   fault_tmo_o                 : last fault was a timeout (0 = decode miss)
//   fault_adr_o                 : address of the last fault
// ----------------------------------------------------------------------------
module wb_mux_tmo
   import wb_mux_tmo_pkg::*;
#(
   parameter int                       NUM_SLAVES     = 8,
   parameter int                       AW             = 32,
   parameter int                       DW             = 32,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR     = '0,
   parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK     = '1,
   parameter int                       TIMEOUT_CYCLES = 255,
   parameter int                       CNT_W          = 8
)(
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_n_i,
   input  logic [AW-1:0]                 wbm_adr_i,
   input  logic [DW-1:0]                 wbm_dat_i,
   input  logic [DW/8-1:0]               wbm_sel_i,
   input  logic                          wbm_we_i,
   input  logic                          wbm_cyc_i,
   input  logic                          wbm_stb_i,
   input  logic [2:0]                    wbm_cti_i,
   input  logic [1:0]                    wbm_bte_i,
   output logic [DW-1:0]                 wbm_dat_o,
   output logic                          wbm_ack_o,
   output logic                          wbm_err_o,
   output logic                          wbm_rty_o,
   output logic [NUM_SLAVES*AW-1:0]      wbs_adr_o,
   output logic [NUM_SLAVES*DW-1:0]      wbs_dat_o,
   output logic [NUM_SLAVES*(DW/8)-1:0]  wbs_sel_o,
   output logic [NUM_SLAVES-1:0]         wbs_we_o,
   output logic [NUM_SLAVES-1:0]         wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]         wbs_stb_o,
   output logic [NUM_SLAVES*3-1:0]       wbs_cti_o,
   output logic [NUM_SLAVES*2-1:0]       wbs_bte_o,
   input  logic [NUM_SLAVES*DW-1:0]      wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]         wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]         wbs_err_i,
   input  logic [NUM_SLAVES-1:0]         wbs_rty_i,
   output logic                          fault_o,
   output logic                          fault_tmo_o,
   output logic [AW-1:0]                 fault_adr_o
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   wdog_q, wdog_d;
   logic               fault_tmo_q, fault_tmo_d;
   logic [AW-1:0]      fault_adr_q, fault_adr_d;

   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic [NUM_SLAVES-1:0] sel_oh;
   logic [DW-1:0]      sel_dat;
   logic               term;
   logic [CNT_W-1:0]   wdog_inc;
   logic               wdog_expired;

   wb_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .AW         (AW),
      .MATCH_ADDR (MATCH_ADDR),
      .MATCH_MASK (MATCH_MASK)
   ) u_decode (
      .adr_i (wbm_adr_i),
      .hit_o (dec_hit),
      .idx_o (dec_idx)
   );

   // Non-strobe signals go to every slave; only cyc/stb select one.
   assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
   assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
   assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
   assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
   assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
   assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

   assign fault_tmo_o = fault_tmo_q;
   assign fault_adr_o = fault_adr_q;

   // One-hot of the registered selection and the matching read-data lane.
   always_comb begin
      sel_oh  = '0;
      sel_dat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_oh[i] = 1'b1;
            sel_dat   = wbs_dat_i[i*DW +: DW];
         end else begin
            sel_oh[i] = 1'b0;
         end
      end
   end

   assign term = |((wbs_ack_i | wbs_err_i | wbs_rty_i) & sel_oh);

   // Saturating increment; the watchdog fires on the cycle the count would
   // reach the limit, i.e. after TIMEOUT_CYCLES unterminated ACTIVE cycles.
   assign wdog_inc     = (&wdog_q) ? wdog_q : (wdog_q + {{(CNT_W-1){1'b0}}, 1'b1});
   assign wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog_inc == CNT_W'(TIMEOUT_CYCLES));

   // State, selection, watchdog and fault capture registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         wdog_q      <= '0;
         fault_tmo_q <= 1'b0;
         fault_adr_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         wdog_q      <= wdog_d;
         fault_tmo_q <= fault_tmo_d;
         fault_adr_q <= fault_adr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      wdog_d      = wdog_q;
      fault_tmo_d = fault_tmo_q;
      fault_adr_d = fault_adr_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (wbm_cyc_i && wbm_stb_i) begin
               sel_d   = dec_idx;
               state_d = dec_hit ? ACTIVE : DERR;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            if (!wbm_cyc_i) begin
               // Master abort: release the slave, no fault.
               state_d = IDLE;
               wdog_d  = '0;
            end else if (term) begin
               wdog_d  = '0;
               state_d = cti_is_burst(wbm_cti_i) ? ACTIVE : IDLE;
            end else if (wbm_stb_i) begin
               wdog_d  = wdog_inc;
               state_d = wdog_expired ? TERR : ACTIVE;
            end else begin
               state_d = ACTIVE;
            end
         end
         DERR: begin
            state_d     = IDLE;
            wdog_d      = '0;
            fault_tmo_d = 1'b0;
            fault_adr_d = wbm_adr_i;
         end
         TERR: begin
            state_d     = IDLE;
            wdog_d      = '0;
            fault_tmo_d = 1'b1;
            fault_adr_d = wbm_adr_i;
         end
         default: begin
            state_d = IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   // Output decode. Responses are gated by the master's cyc so an aborted
   // cycle never leaks a late slave termination back to the master.
   always_comb begin
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
      wbm_ack_o = 1'b0;
      wbm_err_o = 1'b0;
      wbm_rty_o = 1'b0;
      wbm_dat_o = '0;
      fault_o   = 1'b0;
      case (state_q)
         ACTIVE: begin
            wbs_cyc_o = sel_oh & {NUM_SLAVES{wbm_cyc_i}};
            wbs_stb_o = sel_oh & {NUM_SLAVES{wbm_cyc_i & wbm_stb_i}};
            wbm_ack_o = wbm_cyc_i & (|(wbs_ack_i & sel_oh));
            wbm_err_o = wbm_cyc_i & (|(wbs_err_i & sel_oh));
            wbm_rty_o = wbm_cyc_i & (|(wbs_rty_i & sel_oh));
            wbm_dat_o = sel_dat;
         end
         DERR, TERR: begin
            wbm_err_o = 1'b1;
            fault_o   = 1'b1;
         end
         default: begin
            wbm_dat_o = '0;
         end
      endcase
   end

endmodule
